servo_command_driver: RTL

SERVO_COMMAND_DRIVER -- requirements
Module: servo_command_driver

---
 rtl/ball_plate_pkg.sv | 18 +
 rtl/servo_slew_limiter.sv | 36 +++
 rtl/servo_command_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ball_plate_pkg.sv
// Shared constants and types for the ball-and-plate servo path.
package ball_plate_pkg;

  localparam int unsigned CMD_W              = 12;
  localparam logic [CMD_W-1:0] CMD_CENTER    = CMD_W'(2048);

  localparam int unsigned DEF_PERIOD_CYCLES  = 1000000;
  localparam int unsigned DEF_MIN_PULSE      = 50000;
  localparam int unsigned DEF_MAX_PULSE      = 100000;
  localparam int unsigned DEF_MAX_STEP       = 64;
  localparam int unsigned RESET_PULSE_OFFSET = 25000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } servo_state_e;

endpackage

// File: rtl/servo_slew_limiter.sv
// Moves the current command toward the target by at most MAX_STEP LSBs.
module servo_slew_limiter
  import ball_plate_pkg::*;
#(
  parameter int unsigned MAX_STEP = DEF_MAX_STEP
) (
  input  logic [CMD_W-1:0] current,
  input  logic [CMD_W-1:0] target,
  output logic [CMD_W-1:0] result
);

  localparam int unsigned SW = CMD_W + 1;
  localparam logic signed [SW-1:0] STEP_POS = SW'(MAX_STEP);
  localparam logic signed [SW-1:0] STEP_NEG = -STEP_POS;

  logic signed [SW-1:0] diff_c;
  logic signed [SW-1:0] step_c;
  logic signed [SW-1:0] sum_c;

  // Signed difference, clamp to +/-MAX_STEP, add, and keep inside 0..4095.
  always_comb begin
    diff_c = $signed({1'b0, target}) - $signed({1'b0, current});
    step_c = diff_c;
    if (diff_c > STEP_POS) begin
      step_c = STEP_POS;
    end else if (diff_c < STEP_NEG) begin
      step_c = STEP_NEG;
    end
    sum_c  = $signed({1'b0, current}) + step_c;
    result = CMD_W'(sum_c);
    if (sum_c < 0) begin
      result = '0;
    end
  end

endmodule

// File: rtl/servo_command_driver.sv
// Servo PWM generator with per-frame slew-limited command updates.
module servo_command_driver
  import ball_plate_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_PULSE     = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE     = DEF_MAX_PULSE,
  parameter int unsigned MAX_STEP      = DEF_MAX_STEP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CMD_W-1:0] command,
  input  logic             cmd_valid,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [CMD_W-1:0] applied_cmd,
  output logic             cmd_overwrite
);

  localparam int unsigned SPAN         = MAX_PULSE - MIN_PULSE;
  localparam int unsigned RESET_PW_VAL = MIN_PULSE + RESET_PULSE_OFFSET;
  localparam int unsigned PW_TOP       = (MAX_PULSE > RESET_PW_VAL) ? MAX_PULSE : RESET_PW_VAL;
  localparam int unsigned CNT_TOP      = (PERIOD_CYCLES > PW_TOP) ? PERIOD_CYCLES : PW_TOP;
  localparam int unsigned W            = $clog2(CNT_TOP + 1);
  localparam int unsigned SPAN_W       = $clog2(SPAN + 1);
  localparam int unsigned PROD_W       = (CMD_W + SPAN_W < 29) ? 29 : CMD_W + SPAN_W;

  localparam logic [W-1:0]      LAST_CNT = W'(PERIOD_CYCLES - 1);
  localparam logic [W-1:0]      RESET_PW = W'(RESET_PW_VAL);
  localparam logic [W-1:0]      MIN_PW   = W'(MIN_PULSE);
  localparam logic [PROD_W-1:0] SPAN_P   = PROD_W'(SPAN);

  servo_state_e state, state_next;

  logic [W-1:0]      cnt;
  logic [W-1:0]      pulse_width;
  logic [CMD_W-1:0]  target;
  logic              pending;

  logic              boundary_c;
  logic              run_next_c;
  logic [W-1:0]      cnt_next_c;
  logic [W-1:0]      pw_calc_c;
  logic [W-1:0]      pw_next_c;
  logic [CMD_W-1:0]  slew_target_c;
  logic [CMD_W-1:0]  slew_result_c;
  logic [CMD_W-1:0]  applied_next_c;
  logic [PROD_W-1:0] product_c;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the first strobe starts the frames; only reset stops them.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM decode: frame boundary detection and next counter value.
  always_comb begin
    boundary_c = 1'b0;
    cnt_next_c = '0;
    run_next_c = (state_next == ST_RUN);
    case (state)
      ST_IDLE: boundary_c = cmd_valid;
      ST_RUN: begin
        boundary_c = (cnt == LAST_CNT);
        cnt_next_c = boundary_c ? '0 : cnt + W'(1);
      end
      default: boundary_c = 1'b0;
    endcase
  end

  // A strobe on the boundary cycle is used directly for this update.
  assign slew_target_c = cmd_valid ? command : target;

  servo_slew_limiter #(
    .MAX_STEP(MAX_STEP)
  ) u_slew (
    .current(applied_cmd),
    .target (slew_target_c),
    .result (slew_result_c)
  );

  // Command and pulse width only change at the frame boundary.
  always_comb begin
    applied_next_c = boundary_c ? slew_result_c : applied_cmd;
    product_c      = PROD_W'(applied_next_c) * SPAN_P;
    pw_calc_c      = MIN_PW + W'(product_c >> CMD_W);
    pw_next_c      = boundary_c ? pw_calc_c : pulse_width;
  end

  // Datapath and registered outputs; pwm/frame_start reflect the new count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      pending       <= 1'b0;
      target        <= CMD_CENTER;
      applied_cmd   <= CMD_CENTER;
      pulse_width   <= RESET_PW;
      pwm_out       <= 1'b0;
      frame_start   <= 1'b0;
      cmd_overwrite <= 1'b0;
    end else begin
      cnt           <= cnt_next_c;
      applied_cmd   <= applied_next_c;
      pulse_width   <= pw_next_c;
      if (cmd_valid) begin
        target <= command;
      end
      pending       <= boundary_c ? 1'b0 : (pending | cmd_valid);
      cmd_overwrite <= cmd_valid & pending & ~boundary_c;
      frame_start   <= run_next_c & (cnt_next_c == '0);
      pwm_out       <= run_next_c & (cnt_next_c < pw_next_c);
    end
  end

endmodule
